decoder_seq: RTL and testbench
==============================

DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter SEL_W, default 3, select-code width; legal range 1..6.
REQ-002 Parameter DWELL_W, default 8, width of the dwell count.
REQ-003 Derived constant OUT_W = 2**SEL_W, one-hot output width; not overridable.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 in_valid  in  1  command valid.
REQ-007 in_ready  out  1  command accept; a command transfers when in_valid and in_ready are both 1 on a rising edge.
REQ-008 in_mode  in  1  0 = DECODE (single code), 1 = SCAN (walking one).
REQ-009 in_sel  in  SEL_W  code to decode (DECODE), or start position (SCAN).
REQ-010 in_dwell  in  DWELL_W  hold time per position, in cycles minus one.
REQ-011 abort  in  1  cancels any operation in progress.
REQ-012 y  out  OUT_W  registered one-hot output, or all-zero.
REQ-013 y_valid  out  1  1 exactly when y is nonzero.
REQ-014 busy  out  1  1 in HOLD or SCAN.
REQ-015 done  out  1  one-cycle pulse when an operation completes normally.

Function
REQ-016 FSM states: IDLE, HOLD, SCAN; in_ready = 1 only in IDLE with abort = 0.
REQ-017 On accept, the block latches in_mode, in_sel and in_dwell; later changes on these inputs are ignored until the next accept.
REQ-018 DECODE accept: the next cycle has y = 1 << in_sel and the state is HOLD; accept-to-y latency is 1 cycle.
REQ-019 HOLD: y is held for exactly in_dwell+1 cycles (in_dwell = 0 gives 1 cycle). The next cycle then has y = 0, state IDLE and done = 1.
REQ-020 SCAN accept: the next cycle has y = 1 << in_sel and the state is SCAN.
REQ-021 SCAN: each position is held for in_dwell+1 cycles, then the one-hot advances one bit upward.
REQ-022 SCAN wrap-around: bit OUT_W-1 advances to bit 0.
REQ-023 SCAN stops after exactly OUT_W positions (one full lap, ending on bit in_sel-1 mod OUT_W). The next cycle then has y = 0, state IDLE and done = 1.
REQ-024 The dwell counter is DWELL_W bits and counts down from the latched in_dwell to 0. The position counter is SEL_W+1 bits; no overflow is possible.
REQ-025 abort = 1 in any state: the next cycle has y = 0, state IDLE and done = 0; no accept occurs that cycle.
REQ-026 abort and in_valid both 1 in IDLE: abort wins, the command is not accepted and in_ready = 0.
REQ-027 The cycle in which done = 1 is IDLE, so in_ready = 1 and a new command may be accepted that same cycle. Back-to-back throughput is 1 command per (in_dwell+2) cycles in DECODE.
REQ-028 in_sel is always in range, so there is no illegal-code default; y is never multi-hot.

Reset
REQ-029 rst = 1 sets state IDLE, y = 0, y_valid = 0, busy = 0, done = 0, in_ready = 0 and all counters to 0, on the next edge.
REQ-030 rst has priority over abort and in_valid; rst mid-operation discards the operation with no done pulse.
REQ-031 in_ready = 1 from the first cycle after rst deasserts.

Structure
REQ-032 The shared package holds the state enum (IDLE, HOLD, SCAN) and the mode constants MODE_DECODE = 0 and MODE_SCAN = 1.
REQ-033 One sub-module, onehot_dec: a parametrised combinational SEL_W-to-OUT_W decoder that produces the next y value.
REQ-034 All outputs are driven from registers, except in_ready, which is decoded from the state register and abort.

Verification
REQ-035 SEL_W = 3, DECODE, in_sel = 5, in_dwell = 2 -> y = 8'b00100000 for 3 cycles starting 1 cycle after accept, then y = 0 with done = 1.
REQ-036 SCAN, in_sel = 6, in_dwell = 0 -> y takes the values 0x40, 0x80, 0x01, 0x02, ..., 0x20 on consecutive cycles (8 positions), then done = 1.
REQ-037 SCAN with abort asserted on the 3rd position -> y = 0 the next cycle, done stays 0, in_ready = 1.
REQ-038 A new command held valid during the done cycle -> it is accepted that same cycle, and the new y appears on the next cycle with no gap.
REQ-039 rst asserted mid-HOLD -> all outputs 0 on the next edge and no done pulse; in_valid held with abort = 1 -> no accept.
REQ-040 SEL_W = 1 and SEL_W = 6 sweeps -> every code gives exactly one hot bit, and the scan lap length equals OUT_W × (in_dwell+1) cycles.

Source files
------------

// File: rtl/decoder_seq_pkg.sv
// Shared types and constants for the decoder/scan sequencer.
package decoder_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StScan
  } state_e;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_seq_onehot_dec.sv
// Combinational SEL_W-to-OUT_W one-hot decoder; all-zero when disabled.
module onehot_dec #(
  parameter int unsigned SEL_W = 3,
  localparam int unsigned OUT_W = 2 ** SEL_W
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// Command-driven one-hot decoder: holds a single code (DECODE) or walks one
// full lap of positions (SCAN), each position held for dwell+1 cycles.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8,
  localparam int unsigned OUT_W  = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [DWELL_W-1:0] in_dwell,
  input  logic               abort,
  output logic [OUT_W-1:0]   y,
  output logic               y_valid,
  output logic               busy,
  output logic               done
);

  localparam logic [SEL_W:0] LastPos = (SEL_W + 1)'(OUT_W);

  state_e state_q, state_d;
  logic [SEL_W-1:0]   pos_q, pos_d;
  logic [SEL_W:0]     cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] len_q, len_d;
  logic [OUT_W-1:0]   y_d, y_q;
  logic               done_d, done_q, y_valid_q, busy_q;
  logic               accept;

  assign in_ready = (state_q == StIdle) && !abort && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = (in_mode == MODE_SCAN) ? StScan : StHold;
      StHold:  if (dwell_q == '0) state_d = StIdle;
      StScan:  if (dwell_q == '0 && cnt_q == LastPos) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  // Datapath and done: cnt_q counts positions already shown in the current lap.
  always_comb begin
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          pos_d   = in_sel;
          len_d   = in_dwell;
          dwell_d = in_dwell;
          cnt_d   = (SEL_W + 1)'(1);
        end
      end
      StHold: begin
        if (dwell_q == '0) done_d = 1'b1;
        else               dwell_d = dwell_q - 1'b1;
      end
      StScan: begin
        if (dwell_q != '0) begin
          dwell_d = dwell_q - 1'b1;
        end else if (cnt_q == LastPos) begin
          done_d = 1'b1;
        end else begin
          pos_d   = pos_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          dwell_d = len_q;
        end
      end
      default: ;
    endcase
    if (abort) done_d = 1'b0;
  end

  onehot_dec #(
    .SEL_W(SEL_W)
  ) u_dec (
    .en (state_d != StIdle),
    .sel(pos_d),
    .y  (y_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q     <= '0;
      cnt_q     <= '0;
      dwell_q   <= '0;
      len_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      dwell_q   <= dwell_d;
      len_q     <= len_d;
      y_q       <= y_d;
      y_valid_q <= (state_d != StIdle);
      busy_q    <= (state_d != StIdle);
      done_q    <= done_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq at SEL_W = 3, plus SEL_W = 1 and 6 sweeps.
module tb_decoder_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // SEL_W = 3 instance
  logic       valid, mode, abort, ready, yv, busy, done;
  logic [2:0] sel;
  logic [7:0] dwell, y;

  // SEL_W = 1 instance
  logic       v1, m1, a1, r1, yv1, b1, dn1;
  logic [0:0] s1;
  logic [3:0] w1;
  logic [1:0] y1;

  // SEL_W = 6 instance
  logic        v6, m6, a6, r6, yv6, b6, dn6;
  logic [5:0]  s6;
  logic [3:0]  w6;
  logic [63:0] y6;

  decoder_seq #(.SEL_W(3), .DWELL_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(valid), .in_ready(ready), .in_mode(mode),
    .in_sel(sel), .in_dwell(dwell), .abort(abort), .y(y), .y_valid(yv),
    .busy(busy), .done(done)
  );

  decoder_seq #(.SEL_W(1), .DWELL_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_mode(m1),
    .in_sel(s1), .in_dwell(w1), .abort(a1), .y(y1), .y_valid(yv1),
    .busy(b1), .done(dn1)
  );

  decoder_seq #(.SEL_W(6), .DWELL_W(4)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(r6), .in_mode(m6),
    .in_sel(s6), .in_dwell(w6), .abort(a6), .y(y6), .y_valid(yv6),
    .busy(b6), .done(dn6)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    valid = 0; mode = 0; sel = '0; dwell = '0; abort = 0;
    v1 = 0; m1 = 0; s1 = '0; w1 = '0; a1 = 0;
    v6 = 0; m6 = 0; s6 = '0; w6 = '0; a6 = 0;
    step(); step();
    chk("rst_y", 64'(y), 64'h0);
    chk("rst_y_valid", 64'(yv), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_in_ready", 64'(ready), 64'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(ready), 64'h1);

    // DECODE sel=5 dwell=2: three cycles of 0x20, then done
    mode = 0; sel = 3'd5; dwell = 8'd2; valid = 1;
    step();
    valid = 0; sel = 3'd1; dwell = 8'd7; mode = 1;  // must be ignored after accept
    chk("dec_y0", 64'(y), 64'h20);
    chk("dec_y_valid", 64'(yv), 64'h1);
    chk("dec_busy", 64'(busy), 64'h1);
    chk("dec_ready", 64'(ready), 64'h0);
    step(); chk("dec_y1", 64'(y), 64'h20);
    step(); chk("dec_y2", 64'(y), 64'h20); chk("dec_done_early", 64'(done), 64'h0);
    step();
    chk("dec_y_end", 64'(y), 64'h0);
    chk("dec_done", 64'(done), 64'h1);
    chk("dec_busy_end", 64'(busy), 64'h0);
    chk("dec_ready_end", 64'(ready), 64'h1);
    step(); chk("dec_done_pulse", 64'(done), 64'h0);

    // SCAN sel=6 dwell=0: 0x40,0x80,0x01..0x20 then done
    mode = 1; sel = 3'd6; dwell = 8'd0; valid = 1;
    step();
    valid = 0;
    for (int i = 0; i < 8; i++) begin
      chk("scan_y", 64'(y), 64'd1 << ((6 + i) % 8));
      chk("scan_done_low", 64'(done), 64'h0);
      step();
    end
    chk("scan_y_end", 64'(y), 64'h0);
    chk("scan_done", 64'(done), 64'h1);

    // Command presented during the done cycle is taken immediately
    mode = 0; sel = 3'd2; dwell = 8'd0; valid = 1;
    step();
    chk("b2b_y0", 64'(y), 64'h04);
    sel = 3'd3;
    step();
    chk("b2b_done0", 64'(done), 64'h1);
    chk("b2b_ready", 64'(ready), 64'h1);
    step();
    valid = 0;
    chk("b2b_y1", 64'(y), 64'h08);
    chk("b2b_done_low", 64'(done), 64'h0);
    step();
    chk("b2b_done1", 64'(done), 64'h1);
    step();

    // SCAN sel=0 dwell=1, abort on the third position
    mode = 1; sel = 3'd0; dwell = 8'd1; valid = 1;
    step();
    valid = 0;
    chk("ab_p1a", 64'(y), 64'h01);
    step(); chk("ab_p1b", 64'(y), 64'h01);
    step(); chk("ab_p2a", 64'(y), 64'h02);
    step(); chk("ab_p2b", 64'(y), 64'h02);
    step(); chk("ab_p3", 64'(y), 64'h04);
    abort = 1;
    step();
    chk("ab_y", 64'(y), 64'h0);
    chk("ab_done", 64'(done), 64'h0);
    chk("ab_busy", 64'(busy), 64'h0);
    chk("ab_y_valid", 64'(yv), 64'h0);
    abort = 0;
    #1;
    chk("ab_ready", 64'(ready), 64'h1);
    step(); chk("ab_done_later", 64'(done), 64'h0);

    // Reset in the middle of HOLD
    mode = 0; sel = 3'd7; dwell = 8'd5; valid = 1;
    step();
    valid = 0;
    chk("rh_y", 64'(y), 64'h80);
    step();
    rst = 1;
    step();
    chk("rh_y0", 64'(y), 64'h0);
    chk("rh_y_valid", 64'(yv), 64'h0);
    chk("rh_busy", 64'(busy), 64'h0);
    chk("rh_done", 64'(done), 64'h0);
    rst = 0;
    step();
    chk("rh_no_done", 64'(done), 64'h0);
    chk("rh_ready", 64'(ready), 64'h1);

    // Abort beats a valid command in IDLE
    valid = 1; abort = 1;
    #1;
    chk("avl_ready", 64'(ready), 64'h0);
    step();
    chk("avl_busy", 64'(busy), 64'h0);
    chk("avl_y", 64'(y), 64'h0);
    valid = 0; abort = 0;
    step();
    chk("avl_busy_later", 64'(busy), 64'h0);

    // SEL_W = 1 sweep and lap length 2 * (2+1) = 6
    for (int c = 0; c < 2; c++) begin
      m1 = 0; s1 = 1'(c); w1 = 4'd0; v1 = 1;
      step();
      v1 = 0;
      chk("w1_dec", 64'(y1), 64'd1 << c);
      chk("w1_onehot", 64'($onehot(y1)), 64'h1);
      step();
      chk("w1_done", 64'(dn1), 64'h1);
    end
    m1 = 1; s1 = 1'b1; w1 = 4'd2; v1 = 1;
    step();
    v1 = 0;
    cnt = 0;
    while (yv1 && cnt < 40) begin
      cnt++;
      step();
    end
    chk("w1_lap", 64'(cnt), 64'd6);
    chk("w1_lap_done", 64'(dn1), 64'h1);

    // SEL_W = 6 sweep, full walk, and lap length 64 * 2 = 128
    for (int c = 0; c < 64; c++) begin
      m6 = 0; s6 = 6'(c); w6 = 4'd0; v6 = 1;
      step();
      v6 = 0;
      chk("w6_dec", y6, 64'd1 << c);
      step();
      chk("w6_done", 64'(dn6), 64'h1);
    end
    m6 = 1; s6 = 6'd10; w6 = 4'd0; v6 = 1;
    step();
    v6 = 0;
    for (int i = 0; i < 64; i++) begin
      chk("w6_scan", y6, 64'd1 << ((10 + i) % 64));
      step();
    end
    chk("w6_scan_end", y6, 64'h0);
    chk("w6_scan_done", 64'(dn6), 64'h1);
    m6 = 1; s6 = 6'd63; w6 = 4'd1; v6 = 1;
    step();
    v6 = 0;
    cnt = 0;
    while (yv6 && cnt < 300) begin
      cnt++;
      step();
    end
    chk("w6_lap", 64'(cnt), 64'd128);
    chk("w6_lap_done", 64'(dn6), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
